exa_crosb_vc_credit_ctrl: RTL and testbench
===========================================

# exa_crosb_vc_credit_ctrl

Per-output, per-virtual-channel credit controller for the VC crossbar. It keeps one credit counter for every (output, prio×VC) downstream FIFO. Each counter is decremented on every flit the crossbar delivers into that output VC and incremented on every credit returned by the downstream FIFO. From these counters it produces the packet-granular availability vector that the crossbar consumes as `i_output_fifo_credits`. It sits beside the crossbar, between its `M_AXIS` side and the downstream VC FIFOs.

## Interface
- `output_num`, 2: crossbar outputs.
- `prio_num`, 2: priority levels.
- `vc_num`, 2: VCs per priority; NVC = `prio_num*vc_num`.
- `credit_depth`, 16: downstream FIFO depth in flits per output VC; reset/init counter value.
- `max_pkt_flits`, 4: largest packet in flits; availability threshold.
- `init_cycles`, 8: length of the INIT phase in cycles, ≥1.
- `cnt_width`, `log2(credit_depth+1)`: counter width (`ceiling_up_log2.vh`).
- `logVcPrio`, `log2(NVC)`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_init` in 1: one-cycle pulse; re-enters INIT, reloads counters, clears errors.
- `i_flit_valid` in [output_num]: `M_AXIS[o].TVALID`.
- `i_flit_ready` in [output_num]: `M_AXIS[o].TREADY`.
- `i_flit_vc` in [output_num][logVcPrio]: output VC of the flit on output o.
- `i_credit_return` in [output_num][NVC]: one-cycle pulse per returned flit slot; each bit is worth 1 credit.
- `o_output_fifo_credits` out [output_num][NVC]: 1 = the VC can take a whole packet.
- `o_credit_count` out [output_num][NVC][cnt_width]: current counters.
- `o_ready` out 1: 1 in RUN state.
- `o_underflow_err` out 1: sticky; a flit was sent with counter = 0.
- `o_overflow_err` out 1: sticky; a return arrived with counter = `credit_depth`.

## Operation
- **FSM states**
  - INIT: init counter runs 0..`init_cycles`-1; all counters are held at `credit_depth`; `o_output_fifo_credits` = 0; `o_ready` = 0; flit and return inputs are ignored.
  - RUN: normal accounting.
- **FSM transitions**
  - INIT→RUN when the init counter reaches `init_cycles`-1.
  - RUN→INIT on `i_init`.
  - `i_init` during INIT restarts the init counter.
- **Consume event**
  - Condition: RUN, `i_flit_valid[o] & i_flit_ready[o]`.
  - Target: counter (o, `i_flit_vc[o]`).
  - At most one consume per output per cycle.
- **Return event**
  - Condition: RUN, `i_credit_return[o][v]`.
  - Target: counter (o, v).
- **Counter update, per counter, evaluated together**
  - Consume and return in the same cycle: value unchanged, no error.
  - Consume only, count > 0: count − 1.
  - Consume only, count = 0: stays 0; `o_underflow_err` set.
  - Return only, count < `credit_depth`: count + 1.
  - Return only, count = `credit_depth`: stays saturated; `o_overflow_err` set.
- **Availability**
  - `o_output_fifo_credits[o][v]` = RUN & (count ≥ `max_pkt_flits`).
  - Evaluated on the registered count.
  - Checked only at grant time; a packet in flight may drive the count below the threshold.
- **Error flags**: cleared only by reset or `i_init`.

## Timing
- **Reset values**
  - state = INIT, init counter = 0.
  - all counters = `credit_depth`.
  - `o_output_fifo_credits` = 0, `o_ready` = 0.
  - both error flags = 0.
- **RUN entry**: `o_ready` rises `init_cycles` cycles after `resetn` deasserts or after `i_init` is sampled.
- **Latency**: an event sampled on edge t is visible on `o_credit_count` and `o_output_fifo_credits` from t+1.
  - The output arbiter may therefore regrant at t+1 after a last flit and still see a correct count.
- **Handshake**: inputs are sampled, never back-pressured; the block has no ready outputs toward its inputs.
- **Reset mid-packet**: counters are reloaded; the downstream FIFOs must be flushed by the same reset.

## Structure
- **Package `exa_crosb_vc_pkg`**
  - FSM state enum `vc_credit_state_t` {INIT, RUN}.
  - Localparam function for NVC.
- **Sub-module `exa_crosb_credit_counter`**
  - One instance per (output, VC), output_num×NVC in total.
  - Inputs: `consume`, `ret`, `load`.
  - Outputs: `count`, `under`, `over`.
  - Saturating up/down counter with a load input.
- **Top level**: FSM, init counter, `i_flit_vc` one-hot decode, threshold compare, error OR-reduction.

## Test plan
- **Reset then idle**
  - Stimulus: deassert `resetn`, no traffic.
  - Response: `o_ready` = 1 after 8 cycles; all counts = 16; all credit bits = 1.
- **Consume on output 1 VC 2**
  - Stimulus: 13 accepted flits on output 1, VC 2.
  - Response: count = 3; credit bit [1][2] = 0 on the cycle after the 13th flit; other VCs unchanged.
- **Simultaneous events**
  - Stimulus: consume and return on (0, 1) in the same cycle at count = 5.
  - Response: count stays 5; no error.
- **Underflow**
  - Stimulus: count (0, 0) = 0, one more flit.
  - Response: count stays 0; `o_underflow_err` = 1 and stays 1 until `i_init`.
- **Overflow**
  - Stimulus: return on (1, 3) at count = 16.
  - Response: count stays 16; `o_overflow_err` = 1.
- **Re-init mid-traffic**
  - Stimulus: pulse `i_init` with counts partly drained while flits and returns keep arriving.
  - Response: `o_ready` = 0 and credit bits = 0 for 8 cycles, with events ignored; then all counts = 16 and errors = 0.

Source files
------------

// File: rtl/exa_crosb_vc_pkg.sv
// Shared types and helpers for the VC crossbar credit controller.
package exa_crosb_vc_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } vc_credit_state_t;

  function automatic int unsigned calc_nvc(input int unsigned prio_num,
                                           input int unsigned vc_num);
    return prio_num * vc_num;
  endfunction

endpackage

// File: rtl/exa_crosb_credit_counter.sv
// Saturating up/down credit counter for one downstream output VC FIFO.
module exa_crosb_credit_counter #(
  parameter int unsigned credit_depth = 16,
  parameter int unsigned cnt_width    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 consume,
  input  logic                 ret,
  input  logic                 load,
  output logic [cnt_width-1:0] count,
  output logic                 under,
  output logic                 over
);

  localparam logic [cnt_width-1:0] FULL = cnt_width'(credit_depth);

  logic [cnt_width-1:0] count_q, count_d;

  // Simultaneous consume and return cancel out and never flag an error.
  always_comb begin
    count_d = count_q;
    under   = 1'b0;
    over    = 1'b0;
    if (load) begin
      count_d = FULL;
    end else if (consume && !ret) begin
      if (count_q == '0) under   = 1'b1;
      else               count_d = count_q - 1'b1;
    end else if (ret && !consume) begin
      if (count_q == FULL) over    = 1'b1;
      else                 count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= FULL;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/exa_crosb_vc_credit_ctrl.sv
// Per-output, per-VC credit controller producing packet-granular availability.
module exa_crosb_vc_credit_ctrl
  import exa_crosb_vc_pkg::*;
#(
  parameter int unsigned output_num    = 2,
  parameter int unsigned prio_num      = 2,
  parameter int unsigned vc_num        = 2,
  parameter int unsigned credit_depth  = 16,
  parameter int unsigned max_pkt_flits = 4,
  parameter int unsigned init_cycles   = 8,
  parameter int unsigned cnt_width     = $clog2(credit_depth + 1),
  parameter int unsigned logVcPrio     = $clog2(calc_nvc(prio_num, vc_num)),
  localparam int unsigned NVC          = calc_nvc(prio_num, vc_num)
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic                                           i_init,
  input  logic [output_num-1:0]                          i_flit_valid,
  input  logic [output_num-1:0]                          i_flit_ready,
  input  logic [output_num-1:0][logVcPrio-1:0]           i_flit_vc,
  input  logic [output_num-1:0][NVC-1:0]                 i_credit_return,
  output logic [output_num-1:0][NVC-1:0]                 o_output_fifo_credits,
  output logic [output_num-1:0][NVC-1:0][cnt_width-1:0]  o_credit_count,
  output logic                                           o_ready,
  output logic                                           o_underflow_err,
  output logic                                           o_overflow_err
);

  localparam int unsigned ICW = (init_cycles > 1) ? $clog2(init_cycles) : 1;
  localparam logic [ICW-1:0]       INIT_LAST = ICW'(init_cycles - 1);
  localparam logic [cnt_width-1:0] THRESH    = cnt_width'(max_pkt_flits);

  vc_credit_state_t state_q, state_d;
  logic [ICW-1:0]   init_cnt_q, init_cnt_d;
  logic             under_q, under_d;
  logic             over_q, over_d;
  logic             run;
  logic             load;

  logic [output_num-1:0][NVC-1:0] under_w;
  logic [output_num-1:0][NVC-1:0] over_w;

  assign run  = (state_q == RUN);
  // Counters and error flags reload on the i_init edge itself and throughout INIT.
  assign load = i_init || (state_q == INIT);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        if (i_init) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (i_init) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    under_d = load ? 1'b0 : (under_q | (|under_w));
    over_d  = load ? 1'b0 : (over_q  | (|over_w));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      under_q    <= under_d;
      over_q     <= over_d;
    end
  end

  for (genvar o = 0; o < output_num; o++) begin : g_out
    for (genvar v = 0; v < NVC; v++) begin : g_vc
      localparam logic [logVcPrio-1:0] VC_IDX = logVcPrio'(v);

      logic consume;
      logic ret;

      assign consume = run && i_flit_valid[o] && i_flit_ready[o] && (i_flit_vc[o] == VC_IDX);
      assign ret     = run && i_credit_return[o][v];

      exa_crosb_credit_counter #(
        .credit_depth (credit_depth),
        .cnt_width    (cnt_width)
      ) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .consume (consume),
        .ret     (ret),
        .load    (load),
        .count   (o_credit_count[o][v]),
        .under   (under_w[o][v]),
        .over    (over_w[o][v])
      );

      assign o_output_fifo_credits[o][v] = run && (o_credit_count[o][v] >= THRESH);
    end
  end

  assign o_ready         = run;
  assign o_underflow_err = under_q;
  assign o_overflow_err  = over_q;

endmodule

// File: tb/tb_exa_crosb_vc_credit_ctrl.sv
// Directed self-checking bench for the VC credit controller.
module tb_exa_crosb_vc_credit_ctrl;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 init;
  logic [1:0]           flit_valid;
  logic [1:0]           flit_ready;
  logic [1:0][1:0]      flit_vc;
  logic [1:0][3:0]      credit_return;
  logic [1:0][3:0]      credits;
  logic [1:0][3:0][4:0] cnt;
  logic                 ready;
  logic                 under_err;
  logic                 over_err;

  int checks = 0;
  int errors = 0;

  exa_crosb_vc_credit_ctrl #(
    .output_num    (2),
    .prio_num      (2),
    .vc_num        (2),
    .credit_depth  (16),
    .max_pkt_flits (4),
    .init_cycles   (8)
  ) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .i_init                (init),
    .i_flit_valid          (flit_valid),
    .i_flit_ready          (flit_ready),
    .i_flit_vc             (flit_vc),
    .i_credit_return       (credit_return),
    .o_output_fifo_credits (credits),
    .o_credit_count        (cnt),
    .o_ready               (ready),
    .o_underflow_err       (under_err),
    .o_overflow_err        (over_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_counts(input string tag, input logic [4:0] exp);
    for (int o = 0; o < 2; o++)
      for (int v = 0; v < 4; v++)
        chk($sformatf("%s[%0d][%0d]", tag, o, v), 32'(cnt[o][v]), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    flit_valid    = '0;
    flit_ready    = '0;
    flit_vc       = '0;
    credit_return = '0;
  endtask

  initial begin
    resetn = 1'b0;
    init   = 1'b0;
    clr();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_credits", 32'(credits), 32'h00);
    chk("rst_under", 32'(under_err), 32'd0);
    chk("rst_over", 32'(over_err), 32'd0);
    chk_all_counts("rst_cnt", 5'd16);

    // INIT lasts 8 cycles after reset release
    resetn = 1'b1;
    repeat (7) tick();
    chk("init7_ready", 32'(ready), 32'd0);
    chk("init7_credits", 32'(credits), 32'h00);
    tick();
    chk("run_ready", 32'(ready), 32'd1);
    chk("run_credits", 32'(credits), 32'hFF);
    chk_all_counts("run_cnt", 5'd16);

    // 13 flits on (1,2); output 0 offers VC2 without ready and must not count
    flit_vc[1]    = 2'd2;
    flit_valid[1] = 1'b1;
    flit_ready[1] = 1'b1;
    flit_vc[0]    = 2'd2;
    flit_valid[0] = 1'b1;
    repeat (12) tick();
    chk("c12_cnt12", 32'(cnt[1][2]), 32'd4);
    chk("c12_credits", 32'(credits), 32'hFF);
    tick();
    chk("c13_cnt12", 32'(cnt[1][2]), 32'd3);
    chk("c13_credits", 32'(credits), 32'hBF);
    chk("c13_cnt02", 32'(cnt[0][2]), 32'd16);
    chk("c13_cnt13", 32'(cnt[1][3]), 32'd16);
    clr();

    // Drain (0,1) to 5, then simultaneous consume + return
    flit_vc[0]    = 2'd1;
    flit_valid[0] = 1'b1;
    flit_ready[0] = 1'b1;
    repeat (11) tick();
    chk("d01_cnt", 32'(cnt[0][1]), 32'd5);
    credit_return[0][1] = 1'b1;
    tick();
    chk("sim_cnt", 32'(cnt[0][1]), 32'd5);
    chk("sim_under", 32'(under_err), 32'd0);
    chk("sim_over", 32'(over_err), 32'd0);
    flit_valid[0] = 1'b0;
    tick();
    chk("ret01_cnt", 32'(cnt[0][1]), 32'd6);
    clr();

    // Drain (0,0) to zero, then underflow
    flit_vc[0]    = 2'd0;
    flit_valid[0] = 1'b1;
    flit_ready[0] = 1'b1;
    repeat (16) tick();
    chk("d00_cnt", 32'(cnt[0][0]), 32'd0);
    chk("d00_under", 32'(under_err), 32'd0);
    chk("d00_credits", 32'(credits), 32'hBE);
    tick();
    chk("uf_cnt", 32'(cnt[0][0]), 32'd0);
    chk("uf_under", 32'(under_err), 32'd1);
    clr();
    repeat (3) tick();
    chk("uf_sticky", 32'(under_err), 32'd1);
    chk("uf_over", 32'(over_err), 32'd0);

    // Overflow on saturated (1,3), then a normal return on (1,2)
    credit_return[1][3] = 1'b1;
    tick();
    chk("of_cnt", 32'(cnt[1][3]), 32'd16);
    chk("of_over", 32'(over_err), 32'd1);
    credit_return[1][3] = 1'b0;
    credit_return[1][2] = 1'b1;
    tick();
    chk("ret12_cnt", 32'(cnt[1][2]), 32'd4);
    chk("ret12_credits", 32'(credits), 32'hFE);
    clr();

    // Re-init while traffic keeps arriving
    flit_vc[1]          = 2'd1;
    flit_valid[1]       = 1'b1;
    flit_ready[1]       = 1'b1;
    credit_return[0][0] = 1'b1;
    credit_return[1][3] = 1'b1;
    init                = 1'b1;
    tick();
    init = 1'b0;
    chk("ri_ready", 32'(ready), 32'd0);
    chk("ri_credits", 32'(credits), 32'h00);
    chk("ri_under", 32'(under_err), 32'd0);
    chk("ri_over", 32'(over_err), 32'd0);
    chk_all_counts("ri_cnt", 5'd16);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("ri%0d_ready", i), 32'(ready), 32'd0);
      chk($sformatf("ri%0d_credits", i), 32'(credits), 32'h00);
      chk($sformatf("ri%0d_cnt11", i), 32'(cnt[1][1]), 32'd16);
      chk($sformatf("ri%0d_over", i), 32'(over_err), 32'd0);
    end
    clr();
    tick();
    chk("rr_ready", 32'(ready), 32'd1);
    chk("rr_credits", 32'(credits), 32'hFF);
    chk("rr_under", 32'(under_err), 32'd0);
    chk("rr_over", 32'(over_err), 32'd0);
    chk_all_counts("rr_cnt", 5'd16);

    // Accounting resumes after re-init
    flit_vc[1]    = 2'd1;
    flit_valid[1] = 1'b1;
    flit_ready[1] = 1'b1;
    tick();
    clr();
    chk("post_cnt11", 32'(cnt[1][1]), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
